// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants: response codes, the write and read
// channel state encodings, and the response/strobe field widths.
package axi_lite_pkg;

   localparam int RESP_W = 2;
   localparam int STRB_W = 4;

   typedef enum logic [RESP_W-1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

endpackage

// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR and R channels) with master and slave views.
interface axi_lite_slave_mem_if #(
   parameter int ADDR_W = 32
) ();
   import axi_lite_pkg::*;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [RESP_W-1:0] bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [RESP_W-1:0] rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axi_lite_regfile.sv
// Word storage behind the AXI-Lite slave: per-byte write enables, one write
// port and one registered read port. A read and a write to the same word in
// the same cycle return the old contents. Reset clears every word.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              wrEn_i,
   input  logic [IDX_W-1:0]  wrIdx_i,
   input  logic [DATA_W-1:0] wrData_i,
   input  logic [STRB_W-1:0] wrStrb_i,
   input  logic              rdEn_i,
   input  logic [IDX_W-1:0]  rdIdx_i,
   output logic [DATA_W-1:0] rdData_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdData_q;

   // Storage update and read capture; nonblocking reads see pre-write contents
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdData_q <= '0;
      end else begin
         if (rdEn_i) begin
            rdData_q <= mem_q[rdIdx_i];
         end
         if (wrEn_i) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wrStrb_i[b]) begin
                  mem_q[wrIdx_i][8*b +: 8] <= wrData_i[8*b +: 8];
               end
            end
         end
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave with a word-addressed register file behind it. The write
// and read channels run independent FSMs with registered readies/valids.
// Optional feature macro AXI_LITE_SLVERR_EN: out-of-range accesses answer
// SLVERR (writes dropped, reads return 0). Without it, addresses wrap modulo
// DEPTH and every response is OKAY.
module axi_lite_slave_mem
   import axi_lite_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic                 aclk,
   input logic                 areset,
   axi_lite_slave_mem_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef AXI_LITE_SLVERR_EN
   localparam bit SlvErrEn = 1'b1;
`else
   localparam bit SlvErrEn = 1'b0;
`endif

   // Returns {outOfRange, wrapped word index} for a byte address
   function automatic logic [IDX_W:0] decodeAddr(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] offset;
      logic [ADDR_W-1:0] wordIdx;
      logic              outOfRange;
      offset     = addr - BASE_ADDR;
      wordIdx    = offset >> 2;
      outOfRange = (addr < BASE_ADDR) || (wordIdx >= ADDR_W'(DEPTH));
      return {outOfRange, wordIdx[IDX_W-1:0]};
   endfunction

   wr_state_e         wrState_q;
   logic              awready_q;
   logic              wready_q;
   logic              bvalid_q;
   resp_e             bresp_q;
   logic [ADDR_W-1:0] wrAddr_q;
   logic [DATA_W-1:0] wrData_q;
   logic [STRB_W-1:0] wrStrb_q;

   rd_state_e         rdState_q;
   logic              arready_q;
   logic              rvalid_q;
   logic              rdErr_q;
   resp_e             rresp_q;

   logic              awHs;
   logic              wHs;
   logic              arHs;

   logic              commitFire;
   logic [ADDR_W-1:0] commitAddr;
   logic [DATA_W-1:0] commitData;
   logic [STRB_W-1:0] commitStrb;

   logic [IDX_W:0]    wrDecode;
   logic [IDX_W:0]    rdDecode;
   logic              wrErr;
   logic              rdErr;
   resp_e             wrResp;
   resp_e             rdResp;
   logic              rfWrEn;
   logic [DATA_W-1:0] rfRdData;

   assign awHs = bus.awvalid && awready_q;
   assign wHs  = bus.wvalid  && wready_q;
   assign arHs = bus.arvalid && arready_q;

   // Pick the address/data pair that completes a write this cycle: live bus
   // values or whichever half was parked in an earlier cycle
   always_comb begin
      commitFire = 1'b0;
      commitAddr = bus.awaddr;
      commitData = bus.wdata;
      commitStrb = bus.wstrb;
      case (wrState_q)
         W_IDLE: commitFire = awHs && wHs;
         W_ADDR: begin
            commitFire = wHs;
            commitAddr = wrAddr_q;
         end
         W_DATA: begin
            commitFire = awHs;
            commitData = wrData_q;
            commitStrb = wrStrb_q;
         end
         default: commitFire = 1'b0;
      endcase
   end

   assign wrDecode = decodeAddr(commitAddr);
   assign rdDecode = decodeAddr(bus.araddr);
   assign wrErr    = SlvErrEn && wrDecode[IDX_W];
   assign rdErr    = SlvErrEn && rdDecode[IDX_W];
   assign wrResp   = wrErr ? SLVERR : OKAY;
   assign rdResp   = rdErr ? SLVERR : OKAY;
   assign rfWrEn   = commitFire && !wrErr;

   // Write channel FSM: accepts AW and W in either order, then holds B until taken
   always_ff @(posedge aclk) begin
      if (areset) begin
         wrState_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         wrAddr_q  <= '0;
         wrData_q  <= '0;
         wrStrb_q  <= '0;
      end else begin
         case (wrState_q)
            W_IDLE: begin
               if (awHs && wHs) begin
                  wrState_q <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wrResp;
               end else if (awHs) begin
                  wrState_q <= W_ADDR;
                  wrAddr_q  <= bus.awaddr;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (wHs) begin
                  wrState_q <= W_DATA;
                  wrData_q  <= bus.wdata;
                  wrStrb_q  <= bus.wstrb;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_ADDR: begin
               if (wHs) begin
                  wrState_q <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wrResp;
               end
            end
            W_DATA: begin
               if (awHs) begin
                  wrState_q <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wrResp;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  wrState_q <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: wrState_q <= W_IDLE;
         endcase
      end
   end

   // Read channel FSM: one outstanding read, response held until taken
   always_ff @(posedge aclk) begin
      if (areset) begin
         rdState_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= OKAY;
         rdErr_q   <= 1'b0;
      end else begin
         case (rdState_q)
            R_IDLE: begin
               if (arHs) begin
                  rdState_q <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rresp_q   <= rdResp;
                  rdErr_q   <= rdErr;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rdState_q <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: rdState_q <= R_IDLE;
         endcase
      end
   end

   axi_lite_regfile #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .aclk     (aclk),
      .areset   (areset),
      .wrEn_i   (rfWrEn),
      .wrIdx_i  (wrDecode[IDX_W-1:0]),
      .wrData_i (commitData),
      .wrStrb_i (commitStrb),
      .rdEn_i   (arHs),
      .rdIdx_i  (rdDecode[IDX_W-1:0]),
      .rdData_o (rfRdData)
   );

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;
   assign bus.rdata   = rdErr_q ? '0 : rfRdData;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem (DEPTH=16, BASE_ADDR=0).
// Expected B and R responses come from a small memory model and are queued
// when the address handshake happens, then popped when the DUT responds.
module tb_axi_lite_slave_mem;

`ifdef AXI_LITE_SLVERR_EN
   localparam bit SLVERR_ON = 1'b1;
`else
   localparam bit SLVERR_ON = 1'b0;
`endif

   logic clk;
   logic areset;

   int compareCount  = 0;
   int mismatchCount = 0;

   logic [31:0] model [16];
   logic [1:0]  bQueue [$];
   logic [33:0] rQueue [$];

   axi_lite_slave_mem_if #(.ADDR_W(32)) bus ();

   axi_lite_slave_mem #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DEPTH     (16),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .aclk   (clk),
      .areset (areset),
      .bus    (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts every comparison and reports each mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Word index for the 16-word map at address 0; anything at or above 0x40 is outside it
   function automatic void modelDecode(input logic [31:0] addr, output logic [3:0] idx, output bit oor);
      idx = addr[5:2];
      oor = (addr[31:6] != 26'd0);
   endfunction

   // Holds every bus input idle and clears the model and scoreboard during a reset pulse
   task automatic pulseReset();
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      areset = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      bQueue.delete();
      rQueue.delete();
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;
   endtask

   // One full write: AW and W offered after their own delays, B accepted after bDelay extra cycles
   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDelay, input int wDelay, input int bDelay);
      bit          awDone = 1'b0;
      bit          wDone  = 1'b0;
      bit          awHs;
      bit          wHs;
      int          cyc = 0;
      int          n   = 0;
      logic [3:0]  idx;
      bit          oor;
      logic [1:0]  expResp;
      while (!(awDone && wDone) && cyc < 50) begin
         if (!awDone && cyc >= awDelay) begin
            bus.awaddr  = addr;
            bus.awvalid = 1'b1;
         end
         if (!wDone && cyc >= wDelay) begin
            bus.wdata  = data;
            bus.wstrb  = strb;
            bus.wvalid = 1'b1;
         end
         @(negedge clk);
         awHs = bus.awvalid && bus.awready;
         wHs  = bus.wvalid && bus.wready;
         if (awDone) checkOutput("awreadyHeldLow", bus.awready, 1'b0);
         if (wDone)  checkOutput("wreadyHeldLow", bus.wready, 1'b0);
         @(posedge clk);
         #1;
         if (awHs) begin
            awDone = 1'b1;
            bus.awvalid = 1'b0;
         end
         if (wHs) begin
            wDone = 1'b1;
            bus.wvalid = 1'b0;
         end
         cyc++;
      end
      if (!(awDone && wDone)) begin
         checkOutput("writeHandshakeTimeout", {awDone, wDone}, 2'b11);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
         return;
      end
      modelDecode(addr, idx, oor);
      if (SLVERR_ON && oor) begin
         expResp = 2'b10;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         end
         expResp = 2'b00;
      end
      bQueue.push_back(expResp);
      @(negedge clk);
      checkOutput("bvalidLatency", bus.bvalid, 1'b1);
      for (int i = 0; i < bDelay; i++) begin
         @(negedge clk);
         checkOutput("bvalidHeld", bus.bvalid, 1'b1);
         checkOutput("brespHeld", bus.bresp, bQueue[0]);
         checkOutput("awreadyDuringB", bus.awready, 1'b0);
         checkOutput("wreadyDuringB", bus.wready, 1'b0);
      end
      while (!bus.bvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.bvalid) begin
         checkOutput("bvalidTimeout", bus.bvalid, 1'b1);
         return;
      end
      bus.bready = 1'b1;
      if (bQueue.size() == 0) begin
         checkOutput("unexpectedB", bus.bvalid, 1'b0);
      end else begin
         checkOutput("bresp", bus.bresp, bQueue.pop_front());
      end
      @(posedge clk);
      #1;
      bus.bready = 1'b0;
   endtask

   // One full read: AR offered after arDelay, R accepted after rDelay extra cycles
   task automatic axiRead(input logic [31:0] addr, input int arDelay, input int rDelay);
      bit          arDone = 1'b0;
      bit          arHs;
      int          cyc = 0;
      int          n   = 0;
      logic [3:0]  idx;
      bit          oor;
      logic [33:0] expR;
      while (!arDone && cyc < 50) begin
         if (cyc >= arDelay) begin
            bus.araddr  = addr;
            bus.arvalid = 1'b1;
         end
         @(negedge clk);
         arHs = bus.arvalid && bus.arready;
         if (arHs) begin
            modelDecode(addr, idx, oor);
            if (SLVERR_ON && oor) rQueue.push_back({2'b10, 32'h0});
            else                  rQueue.push_back({2'b00, model[idx]});
         end
         @(posedge clk);
         #1;
         if (arHs) begin
            arDone = 1'b1;
            bus.arvalid = 1'b0;
         end
         cyc++;
      end
      if (!arDone) begin
         checkOutput("readHandshakeTimeout", arDone, 1'b1);
         bus.arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      checkOutput("rvalidLatency", bus.rvalid, 1'b1);
      for (int i = 0; i < rDelay; i++) begin
         @(negedge clk);
         checkOutput("rvalidHeld", bus.rvalid, 1'b1);
         checkOutput("rdataHeld", bus.rdata, rQueue[0][31:0]);
         checkOutput("arreadyDuringR", bus.arready, 1'b0);
      end
      while (!bus.rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rvalid) begin
         checkOutput("rvalidTimeout", bus.rvalid, 1'b1);
         return;
      end
      bus.rready = 1'b1;
      if (rQueue.size() == 0) begin
         checkOutput("unexpectedR", bus.rvalid, 1'b0);
      end else begin
         expR = rQueue.pop_front();
         checkOutput("rdata", bus.rdata, expR[31:0]);
         checkOutput("rresp", bus.rresp, expR[33:32]);
      end
      @(posedge clk);
      #1;
      bus.rready = 1'b0;
   endtask

   // Random write-then-read pairs over twice the mapped range, with random strobes and delays
   task automatic applyStimulus(input int count);
      for (int k = 0; k < count; k++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 31)) << 2;
         axiWrite(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
         axiRead(a, $urandom_range(0, 2), $urandom_range(0, 1));
      end
   endtask

   // Safety net so the run always ends even if a bounded wait is somehow skipped
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      int n;
      areset      = 1'b1;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;

      $display("[TB] reset values");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("resetAwready", bus.awready, 1'b0);
      checkOutput("resetWready", bus.wready, 1'b0);
      checkOutput("resetArready", bus.arready, 1'b0);
      checkOutput("resetBvalid", bus.bvalid, 1'b0);
      checkOutput("resetRvalid", bus.rvalid, 1'b0);
      checkOutput("resetBresp", bus.bresp, 2'b00);
      checkOutput("resetRresp", bus.rresp, 2'b00);
      checkOutput("resetRdata", bus.rdata, 32'h0);
      @(posedge clk);
      #1;
      areset = 1'b0;
      @(negedge clk);
      checkOutput("awreadyFirstCycleAfterReset", bus.awready, 1'b0);
      @(negedge clk);
      checkOutput("awreadyRisen", bus.awready, 1'b1);
      checkOutput("wreadyRisen", bus.wready, 1'b1);
      checkOutput("arreadyRisen", bus.arready, 1'b1);
      @(posedge clk);
      #1;

      $display("[TB] AW and W together, then read back");
      axiWrite(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axiRead(32'h04, 0, 0);

      $display("[TB] W three cycles before AW");
      axiWrite(32'h08, 32'h11223344, 4'hF, 3, 0, 0);
      axiRead(32'h08, 0, 0);

      $display("[TB] AW two cycles before W");
      axiWrite(32'h10, 32'h55667788, 4'hF, 0, 2, 0);
      axiRead(32'h10, 1, 0);

      $display("[TB] partial and empty strobes");
      axiWrite(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      axiWrite(32'h0C, 32'h00000011, 4'b0001, 0, 0, 0);
      axiRead(32'h0C, 0, 0);
      axiWrite(32'h0C, 32'h12345678, 4'b0000, 0, 0, 0);
      axiRead(32'h0C, 0, 0);
      axiWrite(32'h0C, 32'h99887766, 4'b1010, 1, 1, 0);
      axiRead(32'h0C, 0, 0);

      $display("[TB] B and R backpressure");
      axiWrite(32'h18, 32'h0BADF00D, 4'hF, 0, 0, 5);
      axiRead(32'h18, 0, 4);

      $display("[TB] out-of-range address 0x40");
      axiWrite(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      axiRead(32'h40, 0, 0);
      axiRead(32'h00, 0, 0);
      axiRead(32'h7C, 0, 0);

      $display("[TB] same-word write and read in one cycle");
      axiWrite(32'h14, 32'h01020304, 4'hF, 0, 0, 0);
      fork
         axiWrite(32'h14, 32'hF0E0D0C0, 4'hF, 0, 0, 0);
         axiRead(32'h14, 0, 0);
      join
      axiRead(32'h14, 0, 0);

      $display("[TB] reset while the write address is parked");
      bus.awaddr  = 32'h18;
      bus.awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.awready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("parkAwHandshake", bus.awready, 1'b1);
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      pulseReset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("noBAfterReset", bus.bvalid, 1'b0);
         @(posedge clk);
         #1;
      end
      for (int w = 0; w < 16; w++) begin
         axiRead(32'(w) << 2, 0, 0);
      end
      axiWrite(32'h18, 32'h600DCAFE, 4'hF, 0, 0, 0);
      axiRead(32'h18, 0, 0);

      $display("[TB] random traffic");
      applyStimulus(24);

      checkOutput("bQueueDrained", 32'(bQueue.size()), 32'd0);
      checkOutput("rQueueDrained", 32'(rQueue.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
